// File: rtl/rc_lowpass_filter.sv
// First-order RC low-pass stage: y += alpha*(x - y) once per audio sample.
// Q16.16 accumulator, coefficient applied by a 16-cycle serial shift-add multiplier.
`timescale 1ns/1ps
module rc_lowpass_filter #(
   parameter longint CLOCK_RATE               = 64'sd50000000,
   parameter longint SAMPLE_RATE              = 64'sd48000,
   parameter longint R                        = 64'sd10000,
   parameter longint C_MICROFARADS_16_SHIFTED = 64'sd6554
) (
   input  logic               clk,
   input  logic               I_RSTn,
   input  logic               audio_clk_en,
   input  logic signed [15:0] in,
   output logic signed [15:0] out,
   output logic               out_valid
);

   localparam longint ALPHA_NUM = 64'sd4294967296 * 64'sd1000000;
   localparam longint ALPHA_DEN = R * C_MICROFARADS_16_SHIFTED * SAMPLE_RATE
                                  + 64'sd65536 * 64'sd1000000;
   localparam longint ALPHA_RAW = ALPHA_NUM / ALPHA_DEN;
   localparam logic [15:0] ALPHA = (ALPHA_RAW < 64'sd1)     ? 16'd1 :
                                   (ALPHA_RAW > 64'sd65535) ? 16'hFFFF : ALPHA_RAW[15:0];

   // The serial multiply needs 18 clocks per sample.
   if (CLOCK_RATE < SAMPLE_RATE * 64'sd18) begin : g_rate_chk
      $error("rc_lowpass_filter: clock too slow for the sample rate");
   end

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_UPDATE = 2'd2} state_t;

   state_t             state_r, state_nx_s;
   logic signed [31:0] acc_r;
   logic [49:0]        mcand_r;
   logic [49:0]        prod_r;
   logic [15:0]        alpha_sh_r;
   logic [3:0]         cnt_r;
   logic               pending_r;
   logic [15:0]        pending_x_r;
   logic signed [15:0] out_r;
   logic               out_valid_r;

   logic               start_s;
   logic [15:0]        sel_x_s;
   logic [33:0]        diff_s;
   logic [34:0]        sum_s;
   logic signed [31:0] acc_nx_s;

   function automatic logic signed [31:0] sat32(input logic signed [34:0] v);
      if (v > 35'sh0_7FFF_FFFF) begin
         sat32 = 32'sh7FFF_FFFF;
      end else if (v < 35'sh7_8000_0000) begin
         sat32 = 32'sh8000_0000;
      end else begin
         sat32 = v[31:0];
      end
   endfunction

   // State register
   always_ff @(posedge clk or negedge I_RSTn) begin
      if (!I_RSTn) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (audio_clk_en || pending_r) state_nx_s = S_MUL;
            else                           state_nx_s = S_IDLE;
         end
         S_MUL: begin
            if (cnt_r == 4'd15) state_nx_s = S_UPDATE;
            else                state_nx_s = S_MUL;
         end
         S_UPDATE: state_nx_s = S_IDLE;
         default:  state_nx_s = S_IDLE;
      endcase
   end

   // Output/datapath decode; a live strobe beats a queued sample
   always_comb begin
      start_s  = (state_r == S_IDLE) && (audio_clk_en || pending_r);
      sel_x_s  = audio_clk_en ? in : pending_x_r;
      diff_s   = {{2{sel_x_s[15]}}, sel_x_s, 16'h0000} - {{2{acc_r[31]}}, acc_r};
      sum_s    = {{3{acc_r[31]}}, acc_r} + {prod_r[49], prod_r[49:16]};
      acc_nx_s = sat32($signed(sum_s));
   end

   // Single-entry sample queue for strobes that arrive while busy
   always_ff @(posedge clk or negedge I_RSTn) begin
      if (!I_RSTn) begin
         pending_r   <= 1'b0;
         pending_x_r <= 16'h0000;
      end else if ((state_r != S_IDLE) && audio_clk_en) begin
         pending_r   <= 1'b1;
         pending_x_r <= in;
      end else if (start_s) begin
         pending_r   <= 1'b0;
      end
   end

   // Shift-add multiplier and accumulator update
   always_ff @(posedge clk or negedge I_RSTn) begin
      if (!I_RSTn) begin
         acc_r      <= 32'sh0000_0000;
         mcand_r    <= 50'h0;
         prod_r     <= 50'h0;
         alpha_sh_r <= 16'h0000;
         cnt_r      <= 4'd0;
         out_r      <= 16'sh0000;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (start_s) begin
                  mcand_r    <= {{16{diff_s[33]}}, diff_s};
                  prod_r     <= 50'h0;
                  alpha_sh_r <= ALPHA;
                  cnt_r      <= 4'd0;
               end
            end
            S_MUL: begin
               if (alpha_sh_r[0]) prod_r <= prod_r + mcand_r;
               mcand_r    <= {mcand_r[48:0], 1'b0};
               alpha_sh_r <= {1'b0, alpha_sh_r[15:1]};
               cnt_r      <= cnt_r + 4'd1;
            end
            S_UPDATE: begin
               acc_r <= acc_nx_s;
               out_r <= acc_nx_s[31:16];
            end
            default: begin
               cnt_r <= 4'd0;
            end
         endcase
      end
   end

   // Valid pulse registered alongside the output word
   always_ff @(posedge clk or negedge I_RSTn) begin
      if (!I_RSTn) begin
         out_valid_r <= 1'b0;
      end else begin
         out_valid_r <= (state_r == S_UPDATE);
      end
   end

   assign out       = out_r;
   assign out_valid = out_valid_r;

endmodule

// File: tb/tb_rc_lowpass_filter.sv
// Directed bench for rc_lowpass_filter: single-step vector table plus
// convergence, back-to-back, reset-abort and full-scale sequences.
`timescale 1ns/1ps
module tb_rc_lowpass_filter;

   logic               clk = 1'b0;
   logic               I_RSTn = 1'b0;
   logic               audio_clk_en = 1'b0;
   logic signed [15:0] in = 16'sd0;
   logic signed [15:0] out;
   logic               out_valid;

   int n_vec = 0;
   int n_err = 0;

   rc_lowpass_filter dut (
      .clk(clk), .I_RSTn(I_RSTn), .audio_clk_en(audio_clk_en),
      .in(in), .out(out), .out_valid(out_valid)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic signed [15:0] x;
      logic signed [15:0] y;
   } vec_t;

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      I_RSTn = 1'b0; audio_clk_en = 1'b0; in = 16'sd0;
      repeat (3) @(negedge clk);
      I_RSTn = 1'b1;
      @(negedge clk);
   endtask

   // One strobe, then watch win negedges: latency of first pulse, its out, pulse count
   task automatic strobe_wait(input logic signed [15:0] x, input int win,
                              output int lat, output logic signed [15:0] y, output int npulse);
      lat = -1; y = 16'sd0; npulse = 0;
      @(negedge clk);
      audio_clk_en = 1'b1; in = x;
      for (int k = 1; k <= win; k++) begin
         @(negedge clk);
         audio_clk_en = 1'b0;
         if (out_valid) begin
            npulse++;
            if (lat < 0) begin lat = k; y = out; end
         end
      end
   endtask

   vec_t tbl[9];
   int lat, np;
   logic signed [15:0] y, prev;
   int bad;
   int pulse_k[$];
   logic signed [15:0] pulse_y[$];

   initial begin
      // expected out = floor(x*1337/65536) from acc = 0
      tbl[0] = '{16'sd16384,  16'sd334};
      tbl[1] = '{16'sd1000,   16'sd20};
      tbl[2] = '{-16'sd16384, -16'sd335};
      tbl[3] = '{16'sd32767,  16'sd668};
      tbl[4] = '{-16'sd32768, -16'sd669};
      tbl[5] = '{16'sd49,     16'sd0};
      tbl[6] = '{16'sd50,     16'sd1};
      tbl[7] = '{-16'sd1,     -16'sd1};
      tbl[8] = '{16'sd0,      16'sd0};

      for (int i = 0; i < 9; i++) begin
         do_reset();
         check($sformatf("rst_out[%0d]", i), int'(out), 0);
         check($sformatf("rst_valid[%0d]", i), int'(out_valid), 0);
         strobe_wait(tbl[i].x, 30, lat, y, np);
         check($sformatf("step_lat[%0d]", i), lat, 18);
         check($sformatf("step_out[%0d]", i), int'(y), int'(tbl[i].y));
         check($sformatf("step_pulses[%0d]", i), np, 1);
      end

      // Convergence up then down, spacing 21 clocks
      do_reset();
      bad = 0; prev = 16'sd0;
      for (int s = 0; s < 500; s++) begin
         strobe_wait(16'sd16384, 20, lat, y, np);
         if (lat != 18 || y < prev || y > 16'sd16384) bad++;
         prev = y;
      end
      check("rise_monotonic", bad, 0);
      check("rise_final", int'(out == 16'sd16383 || out == 16'sd16384), 1);
      bad = 0;
      for (int s = 0; s < 700; s++) begin
         strobe_wait(-16'sd16384, 20, lat, y, np);
         if (lat != 18 || y > prev || y < -16'sd16385) bad++;
         prev = y;
      end
      check("fall_monotonic", bad, 0);
      check("fall_final", int'(out == -16'sd16384 || out == -16'sd16385), 1);

      // Back-to-back strobes at cycles 0, 5, 9
      do_reset();
      pulse_k.delete(); pulse_y.delete();
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (out_valid) begin pulse_k.push_back(k); pulse_y.push_back(out); end
         audio_clk_en = (k == 0 || k == 5 || k == 9);
         in = (k == 0) ? 16'sd1000 : (k == 5) ? 16'sd2000 : 16'sd3000;
      end
      audio_clk_en = 1'b0;
      check("b2b_pulses", pulse_k.size(), 2);
      if (pulse_k.size() == 2) begin
         check("b2b_first_at", pulse_k[0], 18);
         check("b2b_first_out", int'(pulse_y[0]), 20);
         check("b2b_second_at", pulse_k[1], 36);
         check("b2b_second_out", int'(pulse_y[1]), 81);
      end

      // Reset mid-multiply
      do_reset();
      strobe_wait(16'sd16384, 20, lat, y, np);
      check("pre_abort_out", int'(out), 334);
      @(negedge clk);
      audio_clk_en = 1'b1; in = 16'sd8000;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         audio_clk_en = 1'b0;
      end
      I_RSTn = 1'b0;
      #1;
      check("abort_out_async", int'(out), 0);
      check("abort_valid_async", int'(out_valid), 0);
      repeat (2) @(negedge clk);
      I_RSTn = 1'b1;
      np = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (out_valid) np++;
      end
      check("abort_no_pulse", np, 0);
      strobe_wait(16'sd16384, 40, lat, y, np);
      check("abort_restart_lat", lat, 18);
      check("abort_restart_out", int'(y), 334);
      check("abort_restart_pulses", np, 1);

      // Full-scale swing
      do_reset();
      for (int s = 0; s < 600; s++) strobe_wait(-16'sd32768, 20, lat, y, np);
      check("fs_settle", int'(out), -32768);
      bad = 0; prev = out;
      for (int s = 0; s < 50; s++) begin
         strobe_wait(16'sd32767, 20, lat, y, np);
         if (lat != 18 || y <= prev) bad++;
         prev = y;
      end
      check("fs_rise_nowrap", bad, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
